// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: adds two W-bit operands (W = 4*NIBBLES) one nibble per
// cycle through an external combinational 4-bit adder. The nibble operands go
// out on add_a/add_b/add_cin, and add_sum/add_carry come back. Between nibbles
// the carry is chained through a register. The block talks to its controller
// with a start/busy/done handshake.
//
// Optional build macro: NIBBLE_SERIAL_ADDER_OVF_EN
//   When defined, the block adds output ovf. It carries the two's-complement
//   signed overflow of the last addition and is held with result.

module nibble_serial_adder #(
  parameter int unsigned NIBBLES = 4,
  localparam int unsigned W      = 4 * NIBBLES,
  localparam int unsigned IDX_W  = (NIBBLES > 1) ? $clog2(NIBBLES) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  input  logic         cin,
  output logic [3:0]   add_a,
  output logic [3:0]   add_b,
  output logic         add_cin,
  input  logic [3:0]   add_sum,
  input  logic         add_carry,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         cout
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  ,
  output logic         ovf
`endif
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

  logic [1:0]       state_q,  state_d;
  logic [IDX_W-1:0] idx_q,    idx_d;
  logic             carry_q,  carry_d;
  logic [W-1:0]     a_q,      a_d;
  logic [W-1:0]     b_q,      b_d;
  logic [W-1:0]     result_q, result_d;
  logic             cout_q,   cout_d;
  logic             busy_q,   busy_d;
  logic             done_q,   done_d;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  logic             ovf_q,    ovf_d;
`endif

  // Bit offset of the current nibble inside the operand and result registers.
  logic [IDX_W+1:0] bit_off;
  assign bit_off = {idx_q, 2'b00};

  // Next-state, datapath update and the combinational adder-facing outputs.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    cout_d   = cout_q;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    ovf_d    = ovf_q;
`endif
    add_a    = 4'b0;
    add_b    = 4'b0;
    add_cin  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d      = op_a;
          b_d      = op_b;
          carry_d  = cin;
          idx_d    = '0;
          result_d = '0;
          cout_d   = 1'b0;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
          ovf_d    = 1'b0;
`endif
          state_d  = ST_RUN;
        end
      end

      ST_RUN: begin
        add_a   = a_q[bit_off +: 4];
        add_b   = b_q[bit_off +: 4];
        add_cin = carry_q;
        result_d[bit_off +: 4] = add_sum;
        carry_d = add_carry;
        if (idx_q == IDX_LAST) begin
          cout_d  = add_carry;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
          // Overflow: the operand signs agree, but the sign of the sum differs.
          ovf_d   = (a_q[W-1] == b_q[W-1]) && (add_sum[3] != a_q[W-1]);
`endif
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // busy and done are registered from the next state, so they line up with the state.
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign result = result_q;
  assign cout   = cout_q;
  assign busy   = busy_q;
  assign done   = done_q;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  assign ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed and random bench for nibble_serial_adder (NIBBLES=4). The bench
// models the external 4-bit adder as a combinational sum of add_a, add_b and add_cin.
// Define NIBBLE_SERIAL_ADDER_OVF_EN to also check the ovf port.

module tb_nibble_serial_adder;

  localparam int unsigned N = 4;
  localparam int unsigned W = 4 * N;
  localparam int MAX_WAIT = 40;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         cin = 1'b0;
  logic [3:0]   add_a, add_b, add_sum;
  logic         add_cin, add_carry;
  logic         busy, done, cout;
  logic [W-1:0] result;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  logic         ovf;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // External combinational 4-bit adder.
  assign {add_carry, add_sum} = 5'(add_a) + 5'(add_b) + 5'(add_cin);

  nibble_serial_adder #(.NIBBLES(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op_a      (op_a),
    .op_b      (op_b),
    .cin       (cin),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_cin   (add_cin),
    .add_sum   (add_sum),
    .add_carry (add_carry),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .cout      (cout)
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  // Pulse start for one edge, then wait (bounded) for done. Returns what was observed.
  task automatic do_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                        output logic [W-1:0] got_res, output logic got_cout,
                        output logic got_ovf, output int edges, output int busy_cnt,
                        output bit seen);
    op_a = a; op_b = b; cin = c; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    edges = 0; busy_cnt = 0; seen = 0; got_ovf = 1'b0;
    if (busy) busy_cnt++;
    for (int i = 0; i < MAX_WAIT; i++) begin
      @(posedge clk); #1;
      edges++;
      if (busy) busy_cnt++;
      if (done) begin seen = 1; break; end
    end
    got_res = result; got_cout = cout;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    got_ovf = ovf;
`endif
  endtask

  task automatic test_reset;
    #3;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (result !== 16'h0000 || cout !== 1'b0) begin errors++; $display("FAIL reset_result got %h/%b want 0000/0", result, cout); end
    checks++; if (add_a !== 4'h0 || add_b !== 4'h0 || add_cin !== 1'b0) begin errors++; $display("FAIL reset_add got %h %h %b want 0 0 0", add_a, add_b, add_cin); end
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL idle_after_reset busy %b done %b want 0 0", busy, done); end
  endtask

  task automatic test_basic;
    logic [W-1:0] r; logic co, ov; int e, bc; bit s;
    do_add(16'h1234, 16'h4321, 1'b0, r, co, ov, e, bc, s);
    checks++; if (!s) begin errors++; $display("FAIL basic_timeout done not seen within %0d edges", MAX_WAIT); end
    checks++; if (e !== N) begin errors++; $display("FAIL basic_latency got %0d edges want %0d", e, N); end
    checks++; if (bc !== N + 1) begin errors++; $display("FAIL basic_busy_cycles got %0d want %0d", bc, N + 1); end
    checks++; if (r !== 16'h5555 || co !== 1'b0) begin errors++; $display("FAIL basic_sum got %h/%b want 5555/0", r, co); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL basic_done_pulse done %b busy %b want 0 0", done, busy); end
    checks++; if (result !== 16'h5555) begin errors++; $display("FAIL basic_hold got %h want 5555", result); end
  endtask

  task automatic test_carry;
    logic [W-1:0] r; logic co, ov; int e, bc; bit s;
    do_add(16'hFFFF, 16'h0001, 1'b0, r, co, ov, e, bc, s);
    checks++; if (!s || r !== 16'h0000 || co !== 1'b1) begin errors++; $display("FAIL carry_ripple got %h/%b seen %0d want 0000/1", r, co, s); end
    @(posedge clk); #1;
    do_add(16'hFFFF, 16'h0000, 1'b1, r, co, ov, e, bc, s);
    checks++; if (!s || r !== 16'h0000 || co !== 1'b1) begin errors++; $display("FAIL carry_cin got %h/%b seen %0d want 0000/1", r, co, s); end
    @(posedge clk); #1;
  endtask

  task automatic test_busy_ignore;
    int dones = 0;
    op_a = 16'h00FF; op_b = 16'h0001; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    op_a = 16'hAAAA; op_b = 16'h5555; start = 1'b1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ignore_busy got %b want 1", busy); end
    @(posedge clk); #1; start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done) dones++;
      @(posedge clk); #1;
    end
    checks++; if (dones !== 1) begin errors++; $display("FAIL ignore_done_count got %0d want 1", dones); end
    checks++; if (result !== 16'h0100 || cout !== 1'b0) begin errors++; $display("FAIL ignore_result got %h/%b want 0100/0", result, cout); end
  endtask

  task automatic test_async_reset;
    logic [W-1:0] r; logic co, ov; int e, bc; bit s;
    op_a = 16'h1234; op_b = 16'h1111; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if (add_a !== 4'h2 || add_b !== 4'h1) begin errors++; $display("FAIL rst_mid_idx2 add_a %h add_b %h want 2 1", add_a, add_b); end
    #2 rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rst_async_ctl busy %b done %b want 0 0", busy, done); end
    checks++; if (result !== 16'h0000 || cout !== 1'b0) begin errors++; $display("FAIL rst_async_result got %h/%b want 0000/0", result, cout); end
    checks++; if (add_a !== 4'h0 || add_b !== 4'h0 || add_cin !== 1'b0) begin errors++; $display("FAIL rst_async_add got %h %h %b want 0 0 0", add_a, add_b, add_cin); end
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_idle busy %b want 0", busy); end
    do_add(16'h8000, 16'h8000, 1'b0, r, co, ov, e, bc, s);
    checks++; if (!s || r !== 16'h0000 || co !== 1'b1) begin errors++; $display("FAIL rst_fresh got %h/%b seen %0d want 0000/1", r, co, s); end
    @(posedge clk); #1;
  endtask

  task automatic test_random;
    logic [W-1:0] a, b, prev; logic c; logic [W:0] exp; bit seen;
    a = 16'($urandom); b = 16'($urandom); c = 1'($urandom);
    op_a = a; op_b = b; cin = c; start = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      exp = 17'(a) + 17'(b) + 17'(c);
      seen = 0;
      for (int i = 0; i < MAX_WAIT; i++) begin
        @(posedge clk); #1;
        if (done) begin seen = 1; break; end
      end
      checks++;
      if (!seen) begin
        errors++; $display("FAIL rand_timeout op %0d", n);
        break;
      end
      if ({cout, result} !== exp) begin
        errors++; $display("FAIL rand_sum op %0d %h+%h+%b got %b/%h want %b/%h", n, a, b, c, cout, result, exp[W], exp[W-1:0]);
      end
      prev = result;
      a = 16'($urandom); b = 16'($urandom); c = 1'($urandom);
      op_a = a; op_b = b; cin = c;
      @(posedge clk); #1;
      checks++;
      if (result !== prev || done !== 1'b0) begin
        errors++; $display("FAIL rand_hold op %0d got %h done %b want %h done 0", n, result, done, prev);
      end
    end
    start = 1'b0;
    repeat (N + 3) @(posedge clk);
    #1;
  endtask

`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  task automatic test_ovf;
    logic [W-1:0] r; logic co, ov; int e, bc; bit s;
    do_add(16'h7FFF, 16'h0001, 1'b0, r, co, ov, e, bc, s);
    checks++; if (!s || r !== 16'h8000 || ov !== 1'b1 || co !== 1'b0) begin errors++; $display("FAIL ovf_pos got %h ovf %b cout %b want 8000 1 0", r, ov, co); end
    @(posedge clk); #1;
    do_add(16'h8000, 16'hFFFF, 1'b0, r, co, ov, e, bc, s);
    checks++; if (!s || r !== 16'h7FFF || ov !== 1'b1 || co !== 1'b1) begin errors++; $display("FAIL ovf_neg got %h ovf %b cout %b want 7FFF 1 1", r, ov, co); end
    @(posedge clk); #1;
    do_add(16'h0003, 16'h0004, 1'b0, r, co, ov, e, bc, s);
    checks++; if (!s || r !== 16'h0007 || ov !== 1'b0) begin errors++; $display("FAIL ovf_none got %h ovf %b want 0007 0", r, ov); end
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_busy_ignore();
    test_async_reset();
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    test_ovf();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
